// File: rtl/letc_core_pkg.sv
// LETC core shared types: stage indices, flush sources, default flush masks.
// Used by the bubble controller and its optional perf counter bank.
package letc_core_pkg;

    localparam int STAGE_F1 = 0;
    localparam int STAGE_F2 = 1;
    localparam int STAGE_D  = 2;
    localparam int STAGE_E1 = 3;
    localparam int STAGE_E2 = 4;
    localparam int STAGE_M  = 5;
    localparam int STAGE_W  = 6;

    localparam int NUM_STAGES_DEF    = STAGE_W + 1;
    localparam int NUM_FLUSH_SRC_DEF = 2;
    localparam int CTR_W_DEF         = 32;

    typedef enum logic [0:0] {
        FLUSH_SRC_EXCEPTION = 1'b0,
        FLUSH_SRC_BRANCH    = 1'b1
    } flush_src_e;

    typedef enum logic {
        PEND_IDLE,
        PEND_DRAIN
    } pend_state_e;

    localparam logic [NUM_STAGES_DEF-1:0] FLUSH_MASK_EXCEPTION = 7'b0111111;
    localparam logic [NUM_STAGES_DEF-1:0] FLUSH_MASK_BRANCH    = 7'b0001111;

    localparam logic [NUM_FLUSH_SRC_DEF-1:0][NUM_STAGES_DEF-1:0] FLUSH_MASK_DEF =
        {FLUSH_MASK_BRANCH, FLUSH_MASK_EXCEPTION};

    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/letc_core_bubble_ctrl_if.sv
// Stall/flush control bundle between the pipeline and the bubble controller.
// The controller is the slave; the pipeline side is the master.
interface letc_core_bubble_ctrl_if
    import letc_core_pkg::*;
#(
    parameter int NUM_STAGES    = NUM_STAGES_DEF,
    parameter int NUM_FLUSH_SRC = NUM_FLUSH_SRC_DEF,
    parameter int CTR_W         = CTR_W_DEF
);
    localparam int SRC_W = width_min1(NUM_FLUSH_SRC);

    logic [NUM_STAGES-1:0]    stage_ready;
    logic [NUM_STAGES-1:0]    hazard_stall;
    logic [NUM_FLUSH_SRC-1:0] flush_req;
    logic                     perf_clear;

    logic [NUM_STAGES-1:0]    stage_flush;
    logic [NUM_STAGES-1:0]    stage_stall;
    logic                     flush_valid;
    logic [SRC_W-1:0]         flush_src;
    logic                     flush_pending;

    logic [NUM_STAGES-1:0][CTR_W-1:0]    perf_stall_cycles;
    logic [NUM_FLUSH_SRC-1:0][CTR_W-1:0] perf_flush_events;

    modport master (
        output stage_ready, hazard_stall, flush_req, perf_clear,
        input  stage_flush, stage_stall, flush_valid, flush_src,
        input  flush_pending, perf_stall_cycles, perf_flush_events
    );

    modport slave (
        input  stage_ready, hazard_stall, flush_req, perf_clear,
        output stage_flush, stage_stall, flush_valid, flush_src,
        output flush_pending, perf_stall_cycles, perf_flush_events
    );

endinterface

// File: rtl/letc_core_bubble_perf.sv
// Saturating perf counter bank: per-stage stall cycles, per-source flushes.
// Clear beats increment; counters hold at all-ones instead of wrapping.
module letc_core_bubble_perf #(
    parameter int NUM_STAGES    = 7,
    parameter int NUM_FLUSH_SRC = 2,
    parameter int CTR_W         = 32,
    parameter int SRC_W         = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic [NUM_STAGES-1:0]               stall_inc,
    input  logic                                flush_valid,
    input  logic [SRC_W-1:0]                    flush_src,
    output logic [NUM_STAGES-1:0][CTR_W-1:0]    stall_cycles,
    output logic [NUM_FLUSH_SRC-1:0][CTR_W-1:0] flush_events
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (clear) begin
                    stall_cycles[s] <= '0;
                end else if (stall_inc[s] && !(&stall_cycles[s])) begin
                    stall_cycles[s] <= stall_cycles[s] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_events <= '0;
        end else begin
            for (int f = 0; f < NUM_FLUSH_SRC; f++) begin
                if (clear) begin
                    flush_events[f] <= '0;
                end else if (flush_valid && (flush_src == SRC_W'(f))
                             && !(&flush_events[f])) begin
                    flush_events[f] <= flush_events[f] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/letc_core_bubble_ctrl.sv
// Pipeline stall/flush controller: prioritised flush arbitration, sticky drains,
// flush-over-stall back-pressure. Perf counters built with LETC_CORE_BUBBLE_PERF_EN.
module letc_core_bubble_ctrl
    import letc_core_pkg::*;
#(
    parameter int NUM_STAGES    = NUM_STAGES_DEF,
    parameter int NUM_FLUSH_SRC = NUM_FLUSH_SRC_DEF,
    parameter int CTR_W         = CTR_W_DEF,
    parameter logic [NUM_FLUSH_SRC-1:0][NUM_STAGES-1:0] FLUSH_MASK = FLUSH_MASK_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    letc_core_bubble_ctrl_if.slave  bus
);

    localparam int SRC_W = width_min1(NUM_FLUSH_SRC);

    logic                  flush_valid;
    logic [SRC_W-1:0]      win;
    logic [NUM_STAGES-1:0] direct_flush;
    logic [NUM_STAGES-1:0] pend;
    logic [NUM_STAGES-1:0] busy;
    logic [NUM_STAGES-1:0] bp;
    logic [NUM_STAGES-1:0] flush_c;
    logic [NUM_STAGES-1:0] stall_c;

    pend_state_e st_q [NUM_STAGES];
    pend_state_e st_d [NUM_STAGES];

    // Lowest index wins; losing requests in the same cycle are dropped.
    always_comb begin
        flush_valid = |bus.flush_req;
        win         = '0;
        for (int i = NUM_FLUSH_SRC - 1; i >= 0; i--) begin
            if (bus.flush_req[i]) begin
                win = SRC_W'(i);
            end
        end
        direct_flush = flush_valid ? FLUSH_MASK[win] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                st_q[s] <= PEND_IDLE;
            end
        end else begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                st_q[s] <= st_d[s];
            end
        end
    end

    // A fresh flush on a busy stage outranks that stage draining.
    always_comb begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            st_d[s] = st_q[s];
            unique case (st_q[s])
                PEND_IDLE: begin
                    if (direct_flush[s] && !bus.stage_ready[s]) begin
                        st_d[s] = PEND_DRAIN;
                    end
                end
                PEND_DRAIN: begin
                    if (bus.stage_ready[s] && !direct_flush[s]) begin
                        st_d[s] = PEND_IDLE;
                    end
                end
                default: st_d[s] = PEND_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_STAGES; s++) begin
            pend[s] = (st_q[s] == PEND_DRAIN);
        end
        flush_c = direct_flush | pend;
        busy    = bus.hazard_stall | ~bus.stage_ready;
        for (int i = 0; i < NUM_STAGES; i++) begin
            bp[i] = |(busy >> i);
        end
        stall_c = bp & ~flush_c;
    end

    assign bus.stage_flush   = flush_c;
    assign bus.stage_stall   = stall_c;
    assign bus.flush_valid   = flush_valid;
    assign bus.flush_src     = win;
    assign bus.flush_pending = |pend;

`ifdef LETC_CORE_BUBBLE_PERF_EN
    letc_core_bubble_perf #(
        .NUM_STAGES    (NUM_STAGES),
        .NUM_FLUSH_SRC (NUM_FLUSH_SRC),
        .CTR_W         (CTR_W),
        .SRC_W         (SRC_W)
    ) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (bus.perf_clear),
        .stall_inc    (stall_c),
        .flush_valid  (flush_valid),
        .flush_src    (win),
        .stall_cycles (bus.perf_stall_cycles),
        .flush_events (bus.perf_flush_events)
    );
`else
    logic perf_unused;
    assign perf_unused           = bus.perf_clear;
    assign bus.perf_stall_cycles = '0;
    assign bus.perf_flush_events = '0;
`endif

`ifndef SYNTHESIS
    a_no_flush_and_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (flush_c & stall_c) == '0);

    a_stall_chain: assert property (@(posedge clk) disable iff (!rst_n)
        (stall_c[NUM_STAGES-1:1] & ~stall_c[NUM_STAGES-2:0]
         & ~flush_c[NUM_STAGES-2:0]) == '0);

    a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({flush_c, stall_c, flush_valid, win, pend}));
`endif

endmodule
